iram_boot_sequencer: RTL and testbench
======================================

# iram_boot_sequencer

Boot sequencer and IRAM port owner for the simple processor. It loads a program image into the instruction RAM from a valid/ready word stream, then hands the IRAM read port to the core and holds the core's `start` high while the core runs. It sits between the top-level loader interface, the IRAM, and the core's `start` input. It drives the IRAM write port, which is otherwise unused in the top level.

## Interface
Parameters:
- `ADDR_W`, 9: IRAM address width.
- `DATA_W`, 16: instruction word width.
- `DEPTH`, 512: IRAM words. Must equal 2**ADDR_W.

Ports:
- `clock`  in  1: single clock. All logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `load_req`  in  1: request a (re)load. Sampled in IDLE and RUN.
- `load_len`  in  ADDR_W+1: number of words to load, 1..DEPTH. Sampled with `load_req`.
- `s_valid`  in  1: a stream word is present.
- `s_data`  in  DATA_W: the stream word.
- `s_ready`  out  1: the sequencer accepts the word.
- `core_pc`  in  ADDR_W: core program-counter low bits.
- `core_read_en`  in  1: core IRAM read enable.
- `iram_addr`  out  ADDR_W: IRAM address.
- `iram_data`  out  DATA_W: IRAM write data.
- `iram_write_en`  out  1: IRAM write enable.
- `iram_read_en`  out  1: IRAM read enable.
- `core_start`  out  1: level signal. The core runs while this is high.
- `busy`  out  1: high in LOAD or FLUSH.
- `done`  out  1: sticky. The last load completed.
- `error`  out  1: sticky. The last request was rejected.

## Operation
States are IDLE, LOAD, FLUSH and RUN. Reset enters IDLE.
- **IDLE**
  - `load_req` with 1 ≤ `load_len` ≤ DEPTH: latch the length, clear the word counter, clear `done` and `error`, then go to LOAD.
  - `load_req` with `load_len` = 0 or > DEPTH: set `error` and stay in IDLE.
- **LOAD**
  - `s_ready` = 1.
  - On each handshake (`s_valid` & `s_ready`):
    - `iram_write_en` = 1, `iram_addr` = counter, `iram_data` = `s_data`. All three are combinational.
    - The counter increments.
  - A handshake with counter = len−1 goes to FLUSH.
  - `load_req` is ignored in LOAD.
- **FLUSH**
  - One idle cycle so that the last synchronous IRAM write lands before the core reads.
  - Then set `done` and go to RUN.
- **RUN**
  - `core_start` = 1.
  - `iram_addr` = `core_pc` and `iram_read_en` = `core_read_en`.
  - `iram_write_en` = 0.
  - A valid `load_req` drops `core_start` and goes to LOAD (reload).
  - An invalid `load_req` sets `error` and the sequencer stays in RUN.
- **Outside RUN:** `iram_read_en` = 0 and `core_start` = 0. `iram_addr` = counter and `iram_data` = `s_data`.
- **Counter:** ADDR_W+1 bits. It never wraps, because the length is bounded at DEPTH, so the DEPTH-th word lands at address DEPTH−1.
- **Reset mid-operation:** the sequencer returns to IDLE immediately. The counter, `done` and `error` clear. Partial IRAM contents are left as-is and have undefined validity.

## Timing
Reset values of all outputs:
- `s_ready`, `iram_write_en`, `iram_read_en`, `core_start`, `busy`, `done` and `error` are 0.
- `iram_addr` is 0.
- `iram_data` follows `s_data`.

Cycle-level behaviour:
- `load_req` is sampled at edge T0. LOAD is active from T0+1.
- With no stalls, the N words are accepted in cycles T0+1..T0+N.
- FLUSH occurs at T0+N+1.
- `core_start` and `done` are high from T0+N+2.
- `s_valid` low stalls LOAD indefinitely. There is no timeout.
- `s_ready` depends only on state. It never depends combinationally on `s_valid`.
- `done` and `error` update on the same edge as the corresponding state transition.
- Reload from RUN: `core_start` falls in the first cycle after the edge that samples `load_req`.

## Structure
- Package `boot_pkg`:
  - state enum `boot_state_t`
  - default `ADDR_W`, `DATA_W` and `DEPTH` constants
- Sub-module `iram_port_mux`: the combinational selection between loader and core for `iram_addr`, `iram_read_en` and `iram_write_en`, keyed on a `run_sel` input.
- The FSM, counter and sticky flags stay in the top module.

## Test plan
- **Basic load:** reset, then `load_req` with `load_len`=4 and words 0x1111..0x4444 with `s_valid` held high.
  - Required: writes to addresses 0..3.
  - Required: `core_start` and `done` rise at T0+6.
  - Required: `iram_addr` then follows `core_pc`.
- **Stalled stream:** `load_len`=3 with a 5-cycle `s_valid` gap after word 1.
  - Required: no write occurs during the gap.
  - Required: `core_start` is delayed by 5 cycles.
  - Required: the words land at addresses 0..2.
- **Bad length:** `load_len`=0, then `load_len`=513.
  - Required: `error`=1 and the state stays IDLE.
  - Required: a following valid `load_req` with `load_len`=1 clears `error`.
- **Full depth:** `load_len`=512.
  - Required: the last write goes to address 511.
  - Required: no wrap and no write to address 0 after word 0.
- **Reload from RUN:** `load_req` with `load_len`=2 while in RUN.
  - Required: `core_start` falls in the next cycle.
  - Required: `done` clears, the reload completes, and `core_start` rises again.
- **Reset mid-load:** assert `reset_n` low after 2 of 4 words.
  - Required: all outputs reach their reset values asynchronously.
  - Required: after release, the state is IDLE with the counter at 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and default geometry for the IRAM boot sequencer.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } boot_state_t;

  localparam int BOOT_ADDR_W = 9;
  localparam int BOOT_DATA_W = 16;
  localparam int BOOT_DEPTH  = 512;

endpackage

// File: rtl/iram_port_mux.sv
// IRAM port steering: the loader owns the port until run_sel hands it to the core.
module iram_port_mux
  import boot_pkg::*;
#(
  parameter int ADDR_W = BOOT_ADDR_W
) (
  input  logic              run_sel_i,
  input  logic [ADDR_W-1:0] core_pc_i,
  input  logic              core_read_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              load_write_en_i,
  output logic [ADDR_W-1:0] iram_addr_o,
  output logic              iram_read_en_o,
  output logic              iram_write_en_o
);

  // Core side never writes; loader side never reads.
  always_comb begin
    iram_addr_o     = load_addr_i;
    iram_read_en_o  = 1'b0;
    iram_write_en_o = 1'b0;
    if (run_sel_i) begin
      iram_addr_o     = core_pc_i;
      iram_read_en_o  = core_read_en_i;
      iram_write_en_o = 1'b0;
    end else begin
      iram_addr_o     = load_addr_i;
      iram_read_en_o  = 1'b0;
      iram_write_en_o = load_write_en_i;
    end
  end

endmodule

// File: rtl/iram_boot_sequencer.sv
// Loads a program image into IRAM from a valid/ready stream, then releases the
// IRAM read port to the core and holds core_start while it runs.
module iram_boot_sequencer
  import boot_pkg::*;
#(
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DATA_W = BOOT_DATA_W,
  parameter int DEPTH  = BOOT_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] core_pc,
  input  logic              core_read_en,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] iram_data,
  output logic              iram_write_en,
  output logic              iram_read_en,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  boot_state_t       state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              len_ok_s;
  logic              load_hs_s;
  logic              last_word_s;
  logic              run_sel_s;

  assign len_ok_s    = (load_len != '0) && (load_len <= DEPTH_C);
  assign s_ready     = (state_q == ST_LOAD);
  assign load_hs_s   = s_ready & s_valid;
  assign last_word_s = (cnt_q == (len_q - ONE_C));
  assign run_sel_s   = (state_q == ST_RUN);

  assign core_start  = run_sel_s;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done        = done_q;
  assign error       = error_q;
  assign iram_data   = s_data;

  // State, counter, latched length and sticky flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state logic; a (re)load request is honoured from both IDLE and RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_req) begin
          if (len_ok_s) begin
            len_d   = load_len;
            cnt_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            state_d = ST_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_hs_s) begin
          cnt_d = cnt_q + ONE_C;
          if (last_word_s) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      // Gap cycle lets the final synchronous write retire before the core reads.
      ST_FLUSH: begin
        done_d  = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  iram_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_port_mux (
    .run_sel_i       (run_sel_s),
    .core_pc_i       (core_pc),
    .core_read_en_i  (core_read_en),
    .load_addr_i     (cnt_q[ADDR_W-1:0]),
    .load_write_en_i (load_hs_s),
    .iram_addr_o     (iram_addr),
    .iram_read_en_o  (iram_read_en),
    .iram_write_en_o (iram_write_en)
  );

endmodule

// File: tb/tb_iram_boot_sequencer.sv
// Directed bench for iram_boot_sequencer: a per-cycle vector table plus
// hand-written stall, bad-length, full-depth and reset sequences.
module tb_iram_boot_sequencer;
  import boot_pkg::*;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int DEPTH = 512;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_req = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [AW-1:0] core_pc = '0;
  logic          core_read_en = 1'b0;
  logic [AW-1:0] iram_addr;
  logic [DW-1:0] iram_data;
  logic          iram_write_en;
  logic          iram_read_en;
  logic          core_start;
  logic          busy;
  logic          done;
  logic          error;

  iram_boot_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_req      (load_req),
    .load_len      (load_len),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .core_pc       (core_pc),
    .core_read_en  (core_read_en),
    .iram_addr     (iram_addr),
    .iram_data     (iram_data),
    .iram_write_en (iram_write_en),
    .iram_read_en  (iram_read_en),
    .core_start    (core_start),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural IRAM: captures every write seen mid-cycle.
  logic [DW-1:0] mem [DEPTH];
  int            wr_cnt  = 0;
  int            wr0_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;

  always @(negedge clock) begin
    if (reset_n && iram_write_en) begin
      mem[iram_addr] = iram_data;
      wr_cnt         = wr_cnt + 1;
      if (iram_addr == '0) wr0_cnt = wr0_cnt + 1;
      last_wr_addr   = iram_addr;
    end
  end

  typedef struct {
    logic          req;
    logic [AW:0]   len;
    logic          sv;
    logic [DW-1:0] sd;
    logic [AW-1:0] pc;
    logic          rd;
    logic          e_rdy;
    logic          e_we;
    logic          e_re;
    logic [AW-1:0] e_addr;
    logic          e_start;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [AW:0] len, input logic sv,
                       input logic [DW-1:0] sd, input logic [AW-1:0] pc, input logic rd);
    load_req     = req;
    load_len     = len;
    s_valid      = sv;
    s_data       = sd;
    core_pc      = pc;
    core_read_en = rd;
  endtask

  task automatic next;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, s_ready, 1'b0);
    chk({tag, "_we"},    iram_write_en, 1'b0);
    chk({tag, "_re"},    iram_read_en, 1'b0);
    chk({tag, "_addr"},  iram_addr, 9'd0);
    chk({tag, "_start"}, core_start, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
    chk({tag, "_err"},   error, 1'b0);
  endtask

  int t;
  int base_wr;
  int base_wr0;

  initial begin
    // req len sv sd pc rd | rdy we re addr start busy done err
    vt[0]  = '{1'b1, 10'd4, 1'b0, 16'h0000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 10'd0, 1'b1, 16'h1111, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 10'd0, 1'b1, 16'h2222, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 9'h001, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 10'd0, 1'b1, 16'h3333, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 9'h002, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 10'd0, 1'b1, 16'h4444, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 9'h003, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h004, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 10'd0, 1'b0, 16'h0000, 9'h010, 1'b1, 1'b0, 1'b0, 1'b1, 9'h010, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 10'd0, 1'b1, 16'hDEAD, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 10'd0, 1'b0, 16'h0000, 9'h020, 1'b1, 1'b0, 1'b0, 1'b1, 9'h020, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 10'd0, 1'b0, 16'h0000, 9'h021, 1'b1, 1'b0, 1'b0, 1'b1, 9'h021, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b1, 10'd2, 1'b0, 16'h0000, 9'h022, 1'b0, 1'b0, 1'b0, 1'b0, 9'h022, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[11] = '{1'b0, 10'd0, 1'b1, 16'hAAAA, 9'h022, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 10'd0, 1'b1, 16'hBBBB, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 9'h001, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 9'h002, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 10'd0, 1'b0, 16'h0000, 9'h005, 1'b1, 1'b0, 1'b0, 1'b1, 9'h005, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values while held in reset.
    drive(1'b0, 10'd0, 1'b1, 16'h1234, 9'h0AB, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    chk("rst_data_follows", iram_data, 16'h1234);
    drive(1'b0, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0);
    reset_n = 1'b1;
    next();

    // Basic load of 4 words, bad length from RUN, reload of 2 words.
    base_wr = wr_cnt;
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].req, vt[i].len, vt[i].sv, vt[i].sd, vt[i].pc, vt[i].rd);
      @(negedge clock);
      chk($sformatf("v%0d_ready", i), s_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_we", i),    iram_write_en, vt[i].e_we);
      chk($sformatf("v%0d_re", i),    iram_read_en, vt[i].e_re);
      chk($sformatf("v%0d_addr", i),  iram_addr, vt[i].e_addr);
      chk($sformatf("v%0d_start", i), core_start, vt[i].e_start);
      chk($sformatf("v%0d_busy", i),  busy, vt[i].e_busy);
      chk($sformatf("v%0d_done", i),  done, vt[i].e_done);
      chk($sformatf("v%0d_err", i),   error, vt[i].e_err);
      if (vt[i].e_we) chk($sformatf("v%0d_data", i), iram_data, vt[i].sd);
      next();
    end
    chk("tbl_wr_cnt", wr_cnt - base_wr, 6);
    chk("tbl_mem0", mem[0], 16'hAAAA);
    chk("tbl_mem1", mem[1], 16'hBBBB);
    chk("tbl_mem2", mem[2], 16'h3333);
    chk("tbl_mem3", mem[3], 16'h4444);

    // Asynchronous reset from RUN with done set.
    drive(1'b0, 10'd0, 1'b0, 16'h0000, 9'h0AB, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("arst_run");
    @(negedge clock);
    reset_n = 1'b1;
    next();

    // Bad lengths in IDLE, then a 1-word load clears error.
    drive(1'b1, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    chk("bad0_err", error, 1'b1);
    chk("bad0_busy", busy, 1'b0);
    drive(1'b1, 10'd513, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    chk("bad513_err", error, 1'b1);
    chk("bad513_ready", s_ready, 1'b0);
    chk("bad513_busy", busy, 1'b0);
    drive(1'b1, 10'd1, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    chk("len1_err_clr", error, 1'b0);
    chk("len1_busy", busy, 1'b1);
    drive(1'b0, 10'd0, 1'b1, 16'h7777, 9'h000, 1'b0);
    @(negedge clock);
    chk("len1_we", iram_write_en, 1'b1);
    chk("len1_addr", iram_addr, 9'd0);
    next();
    drive(1'b0, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0);
    @(negedge clock);
    chk("len1_flush_we", iram_write_en, 1'b0);
    chk("len1_flush_start", core_start, 1'b0);
    next();
    chk("len1_start", core_start, 1'b1);
    chk("len1_done", done, 1'b1);
    chk("len1_mem0", mem[0], 16'h7777);

    // Stalled stream: 3 words with a 5-cycle gap after word 1.
    base_wr = wr_cnt;
    drive(1'b1, 10'd3, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    t = 1;
    drive(1'b0, 10'd0, 1'b1, 16'h0A01, 9'h000, 1'b0);
    next();
    t++;
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 10'd0, 1'b0, 16'hFFFF, 9'h000, 1'b0);
      @(negedge clock);
      chk($sformatf("gap%0d_we", g), iram_write_en, 1'b0);
      chk($sformatf("gap%0d_ready", g), s_ready, 1'b1);
      chk($sformatf("gap%0d_addr", g), iram_addr, 9'd1);
      next();
      t++;
    end
    drive(1'b0, 10'd0, 1'b1, 16'h0A02, 9'h000, 1'b0);
    next();
    t++;
    drive(1'b0, 10'd0, 1'b1, 16'h0A03, 9'h000, 1'b0);
    next();
    t++;
    drive(1'b0, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (core_start) break;
      next();
      t++;
    end
    chk("stall_start_cycle", t, 10);
    chk("stall_wr_cnt", wr_cnt - base_wr, 3);
    chk("stall_mem0", mem[0], 16'h0A01);
    chk("stall_mem1", mem[1], 16'h0A02);
    chk("stall_mem2", mem[2], 16'h0A03);

    // Full depth reload from RUN.
    base_wr  = wr_cnt;
    base_wr0 = wr0_cnt;
    drive(1'b1, 10'd512, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    t = 1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 10'd0, 1'b1, 16'h5000 | 16'(i), 9'h000, 1'b0);
      next();
      t++;
    end
    drive(1'b0, 10'd0, 1'b1, 16'hEEEE, 9'h000, 1'b0);
    @(negedge clock);
    chk("full_flush_we", iram_write_en, 1'b0);
    chk("full_flush_busy", busy, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (core_start) break;
      next();
      t++;
    end
    chk("full_start_cycle", t, 514);
    chk("full_wr_cnt", wr_cnt - base_wr, 512);
    chk("full_wr0_cnt", wr0_cnt - base_wr0, 1);
    chk("full_last_addr", last_wr_addr, 9'd511);
    chk("full_mem0", mem[0], 16'h5000);
    chk("full_mem256", mem[256], 16'h5100);
    chk("full_mem511", mem[511], 16'h51FF);
    chk("full_done", done, 1'b1);

    // Reset after 2 of 4 words, with a third word on the bus.
    drive(1'b1, 10'd4, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    drive(1'b0, 10'd0, 1'b1, 16'h0C01, 9'h000, 1'b0);
    next();
    drive(1'b0, 10'd0, 1'b1, 16'h0C02, 9'h000, 1'b0);
    next();
    drive(1'b0, 10'd0, 1'b1, 16'h0C03, 9'h000, 1'b0);
    #1;
    chk("midrst_pre_we", iram_write_en, 1'b1);
    chk("midrst_pre_addr", iram_addr, 9'd2);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    next();
    @(negedge clock);
    chk("post_rst_ready", s_ready, 1'b0);
    chk("post_rst_we", iram_write_en, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_addr", iram_addr, 9'd0);
    next();
    drive(1'b1, 10'd1, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    drive(1'b0, 10'd0, 1'b1, 16'h9999, 9'h000, 1'b0);
    @(negedge clock);
    chk("post_rst_load_addr", iram_addr, 9'd0);
    chk("post_rst_load_we", iram_write_en, 1'b1);
    next();
    drive(1'b0, 10'd0, 1'b0, 16'h0000, 9'h000, 1'b0);
    next();
    chk("post_rst_run", core_start, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
